// File: rtl/digit_serial_add_sub_pkg.sv
//------------------------------------------------------------------------------
// Module   : digit_serial_add_sub_pkg
// Brief    : Shared FSM state type and sizing helper for the digit-serial add/sub.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package digit_serial_add_sub_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Digit counter width; a single-digit configuration still needs one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_serial_add_sub_if.sv
//------------------------------------------------------------------------------
// Module   : digit_serial_add_sub_if
// Brief    : Start/done request bus of the digit-serial adder/subtractor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface digit_serial_add_sub_if #(
  parameter int M = 32
);

  logic         start;
  logic         sub;
  logic         cin;
  logic [M-1:0] x;
  logic [M-1:0] y;
  logic         busy;
  logic         done;
  logic [M-1:0] out;
  logic         cout;
  logic         v;

  modport master (
    output start, sub, cin, x, y,
    input  busy, done, out, cout, v
  );

  modport slave (
    input  start, sub, cin, x, y,
    output busy, done, out, cout, v
  );

endinterface

`default_nettype wire

// File: rtl/digit_serial_add_sub_slice.sv
//------------------------------------------------------------------------------
// Module   : digit_serial_add_sub_slice
// Brief    : Combinational M-bit ripple-carry adder/subtractor with carry and overflow.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module digit_serial_add_sub_slice #(
  parameter int M = 8
) (
  input  wire logic [M-1:0] a,
  input  wire logic [M-1:0] b,
  input  wire logic         sub,
  input  wire logic         cin,
  output logic      [M-1:0] s,
  output logic              cout,
  output logic              v
);

  logic [M-1:0] w_b;
  logic [M:0]   w_c;

  // Subtraction is a + ~b + ~cin, so cin behaves as a borrow-in.
  assign w_b    = b ^ {M{sub}};
  assign w_c[0] = cin ^ sub;

  for (genvar i = 0; i < M; i++) begin : g_bit
    assign s[i]     = a[i] ^ w_b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & w_b[i]) | (w_c[i] & (a[i] ^ w_b[i]));
  end

  assign cout = w_c[M];
  assign v    = w_c[M] ^ w_c[M-1];

endmodule

`default_nettype wire

// File: rtl/digit_serial_add_sub.sv
//------------------------------------------------------------------------------
// Module   : digit_serial_add_sub
// Brief    : Multi-cycle M-bit add/sub processing D bits per clock, LSB digit first.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module digit_serial_add_sub
  import digit_serial_add_sub_pkg::*;
#(
  parameter int M = 32,
  parameter int D = 8
) (
  input wire logic               clk,
  input wire logic               rst,
  digit_serial_add_sub_if.slave  bus
);

  localparam int N       = M / D;
  localparam int c_cnt_w = cnt_width(N);

  if (M % D != 0) begin : g_bad_digit
    $error("digit_serial_add_sub: M must be a multiple of D");
  end

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_step;

  logic [M-1:0]         r_a;
  logic [M-1:0]         r_b;
  logic                 r_carry;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [M-1:0]         w_a_next;
  logic [M-1:0]         w_b_next;

  logic [D-1:0]         w_sum;
  logic                 w_slice_cout;
  logic                 w_slice_v;
  logic [M-1:0]         w_res_full;

  logic [M-1:0]         r_out;
  logic                 r_cout;
  logic                 r_v;
  logic                 r_done;

  // Operand B is already inverted at capture, so the slice only ever adds.
  digit_serial_add_sub_slice #(
    .M (D)
  ) u_slice (
    .a    (r_a[D-1:0]),
    .b    (r_b[D-1:0]),
    .sub  (1'b0),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_slice_cout),
    .v    (w_slice_v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == c_cnt_w'(N - 1)) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_step = (r_state == RUN);

  if (N > 1) begin : g_shift_multi
    logic [M-D-1:0] r_res;

    assign w_a_next   = {{D{1'b0}}, r_a[M-1:D]};
    assign w_b_next   = {{D{1'b0}}, r_b[M-1:D]};
    // New digits enter at the MSB end; after N digits the result is aligned.
    assign w_res_full = {w_sum, r_res};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_res <= '0;
      end else if (w_step) begin
        r_res <= w_res_full[M-1:D];
      end
    end
  end else begin : g_shift_single
    assign w_a_next   = '0;
    assign w_b_next   = '0;
    assign w_res_full = w_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_cout  <= 1'b0;
      r_v     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a     <= bus.x;
        r_b     <= bus.sub ? ~bus.y : bus.y;
        r_carry <= bus.sub ? ~bus.cin : bus.cin;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_a     <= w_a_next;
        r_b     <= w_b_next;
        r_carry <= w_slice_cout;
        r_cnt   <= r_cnt + c_cnt_w'(1);
        if (w_last) begin
          r_out  <= w_res_full;
          r_cout <= w_slice_cout;
          r_v    <= w_slice_v;
        end
      end
    end
  end

  assign bus.busy = w_step;
  assign bus.done = r_done;
  assign bus.out  = r_out;
  assign bus.cout = r_cout;
  assign bus.v    = r_v;

endmodule

`default_nettype wire
